operand_entry_ctrl: RTL

//   Input-side front end for the arithmetic LED datapath.
//   - Takes 3 slide switches plus ENTER and CLEAR push-buttons.
//   - Walks the user through entering operand A, operand B, then the opcode.
//   - Registers all three and holds them stable with a valid flag, so the

---
 rtl/operand_entry_if.sv | 25 ++
 rtl/operand_entry_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/operand_entry_if.sv
// Switch/button inputs and captured-operation outputs of the operand entry front end.
// The master modport drives the raw inputs; the slave modport is the controller side.
interface operand_entry_if #(
    parameter int W = 3
);
    logic [W-1:0] sw;
    logic         btn_enter;
    logic         btn_clear;
    logic [W-1:0] a_o;
    logic [W-1:0] b_o;
    logic [W-1:0] ctrl_o;
    logic         valid_o;
    logic [1:0]   stage_o;
    logic         err_o;

    modport master (
        output sw, btn_enter, btn_clear,
        input  a_o, b_o, ctrl_o, valid_o, stage_o, err_o
    );

    modport slave (
        input  sw, btn_enter, btn_clear,
        output a_o, b_o, ctrl_o, valid_o, stage_o, err_o
    );
endinterface

// File: rtl/operand_entry_ctrl.sv
// Operand entry front end: debounced ENTER/CLEAR walk the user through A, B, opcode.
// Optional macro DIV0_GUARD_EN rejects divide/modulo opcodes when operand B is zero.
//
// state    | meaning
// ENTER_A  | waiting for ENTER to capture operand A
// ENTER_B  | waiting for ENTER to capture operand B
// ENTER_OP | waiting for ENTER to capture a legal opcode
// SHOW     | complete operation held, valid_o high
module operand_entry_ctrl #(
    parameter int W         = 3,
    parameter int DB_CYCLES = 16,
    parameter int MAX_OP    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    operand_entry_if.slave   bus
);
    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] DB_RELOAD = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ENTER_A  = 2'd0,
        ENTER_B  = 2'd1,
        ENTER_OP = 2'd2,
        SHOW     = 2'd3
    } state_t;

    state_t state, next_state;

    // Index 0 is ENTER, index 1 is CLEAR.
    logic [1:0]    btn_raw;
    logic [1:0]    sync_1, sync_2;
    logic [1:0]    db_lvl, db_lvl_d;
    logic [CW-1:0] db_cnt [2];
    logic [1:0]    press;
    logic          enter_ev, clear_ev;

    assign btn_raw = {bus.btn_clear, bus.btn_enter};

    // Down-counter reloads whenever the synchronised level agrees with the
    // debounced level, so any bounce restarts the full count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1   <= '0;
            sync_2   <= '0;
            db_lvl   <= '0;
            db_lvl_d <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync_1   <= btn_raw;
            sync_2   <= sync_1;
            db_lvl_d <= db_lvl;
            for (int i = 0; i < 2; i++) begin
                if (sync_2[i] == db_lvl[i]) begin
                    db_cnt[i] <= DB_RELOAD;
                end else if (db_cnt[i] == '0) begin
                    db_lvl[i] <= sync_2[i];
                    db_cnt[i] <= DB_RELOAD;
                end else begin
                    db_cnt[i] <= db_cnt[i] - 1'b1;
                end
            end
        end
    end

    assign press    = db_lvl & ~db_lvl_d;
    assign clear_ev = press[1];
    assign enter_ev = press[0] & ~press[1];

    logic [W-1:0] a_q, b_q, ctrl_q;
    logic         err_q;
    logic         op_reject;

`ifdef DIV0_GUARD_EN
    assign op_reject = (bus.sw > W'(MAX_OP)) ||
                       (((bus.sw == W'(3)) || (bus.sw == W'(4))) && (b_q == '0));
`else
    assign op_reject = (bus.sw > W'(MAX_OP));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ENTER_A;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (clear_ev) begin
            next_state = ENTER_A;
        end else if (enter_ev) begin
            case (state)
                ENTER_A:  next_state = ENTER_B;
                ENTER_B:  next_state = ENTER_OP;
                ENTER_OP: next_state = op_reject ? ENTER_OP : SHOW;
                SHOW:     next_state = ENTER_A;
                default:  next_state = ENTER_A;
            endcase
        end
    end

    logic cap_a, cap_b, cap_op, clr_all, err_set;

    always_comb begin
        cap_a   = 1'b0;
        cap_b   = 1'b0;
        cap_op  = 1'b0;
        err_set = 1'b0;
        clr_all = clear_ev;
        if (!clear_ev && enter_ev) begin
            case (state)
                ENTER_A:  cap_a = 1'b1;
                ENTER_B:  cap_b = 1'b1;
                ENTER_OP: begin
                    cap_op  = !op_reject;
                    err_set = op_reject;
                end
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            ctrl_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= err_set;
            if (clr_all) begin
                a_q    <= '0;
                b_q    <= '0;
                ctrl_q <= '0;
            end else begin
                if (cap_a)  a_q    <= bus.sw;
                if (cap_b)  b_q    <= bus.sw;
                if (cap_op) ctrl_q <= bus.sw;
            end
        end
    end

    assign bus.a_o     = a_q;
    assign bus.b_o     = b_q;
    assign bus.ctrl_o  = ctrl_q;
    assign bus.err_o   = err_q;
    assign bus.valid_o = (state == SHOW);
    assign bus.stage_o = state;
endmodule
